// File: rtl/steer_pkg.sv
// Shared types for the quadrature steering emulator: FSM states and Gray phase stepping.
package steer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_R = 2'd1,
        RUN_L = 2'd2
    } state_t;

    // Phase constants as {A,B}
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Right turn: A leads B
    function automatic logic [1:0] phase_cw(input logic [1:0] ph);
        case (ph)
            PH_00:   phase_cw = PH_10;
            PH_10:   phase_cw = PH_11;
            PH_11:   phase_cw = PH_01;
            default: phase_cw = PH_00;
        endcase
    endfunction

    function automatic logic [1:0] phase_ccw(input logic [1:0] ph);
        case (ph)
            PH_00:   phase_ccw = PH_01;
            PH_01:   phase_ccw = PH_11;
            PH_11:   phase_ccw = PH_10;
            default: phase_ccw = PH_00;
        endcase
    endfunction

endpackage

// File: rtl/steer_rate_ctr.sv
// Step-period counter with acceleration: period shrinks by ACCEL_STEP per step down to DIV_MIN.
module steer_rate_ctr
    import steer_pkg::*;
#(
    parameter int DIV_MAX    = 45000,
    parameter int DIV_MIN    = 9000,
    parameter int ACCEL_STEP = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        run,
    input  logic        step,
    output logic [15:0] period,
    output logic        step_due
);

    logic [15:0] r_cnt;
    logic [15:0] r_period;
    logic [16:0] w_dec;
    logic [15:0] w_next_period;

    // Bit 16 set means the subtraction went below zero
    assign w_dec = {1'b0, r_period} - 17'(ACCEL_STEP);
    assign w_next_period = (w_dec[16] || (w_dec[15:0] < 16'(DIV_MIN))) ? 16'(DIV_MIN) : w_dec[15:0];

    assign step_due = (r_cnt == r_period - 16'd1);
    assign period   = r_period;

    always_ff @(posedge clk) begin
        if (reset || load || !run) begin
            r_cnt    <= '0;
            r_period <= 16'(DIV_MAX);
        end else if (step) begin
            r_cnt    <= '0;
            r_period <= w_next_period;
        end else begin
            r_cnt    <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/steer_quad_accel.sv
// Turns left/right steering levels into an accelerating quadrature pair, like a rotary encoder.
module steer_quad_accel
    import steer_pkg::*;
#(
    parameter int DIV_MAX    = 45000,
    parameter int DIV_MIN    = 9000,
    parameter int ACCEL_STEP = 1500
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        c_left,
    input  logic        c_right,
    output logic        steerA,
    output logic        steerB,
    output logic        step_o,
    output logic        dir_o,
    output logic [15:0] period_o
);

    logic        r_l_q;
    logic        r_r_q;
    state_t      r_state;
    logic [1:0]  r_phase;
    logic        r_step;
    logic        r_dir;

    state_t      w_next;
    logic        w_stay;
    logic        w_load;
    logic        w_step;
    logic        w_step_due;
    logic [15:0] w_period;

    always_comb begin
        w_next = IDLE;
        case ({r_l_q, r_r_q})
            2'b01:   w_next = RUN_R;
            2'b10:   w_next = RUN_L;
            default: w_next = IDLE;
        endcase
    end

    // A step only fires when the run continues; release or reversal on the due edge wins
    assign w_stay = (r_state != IDLE) && (w_next == r_state);
    assign w_load = (w_next != IDLE) && !w_stay;
    assign w_step = w_stay && w_step_due;

    steer_rate_ctr #(
        .DIV_MAX    (DIV_MAX),
        .DIV_MIN    (DIV_MIN),
        .ACCEL_STEP (ACCEL_STEP)
    ) u_rate (
        .clk      (CLK),
        .reset    (reset),
        .load     (w_load),
        .run      (w_stay),
        .step     (w_step),
        .period   (w_period),
        .step_due (w_step_due)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_l_q   <= 1'b0;
            r_r_q   <= 1'b0;
            r_state <= IDLE;
            r_phase <= PH_00;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_l_q   <= c_left;
            r_r_q   <= c_right;
            r_state <= w_next;
            r_step  <= w_step;
            if (w_step) begin
                r_dir   <= (r_state == RUN_R);
                r_phase <= (r_state == RUN_R) ? phase_cw(r_phase) : phase_ccw(r_phase);
            end
        end
    end

    assign steerA   = r_phase[1];
    assign steerB   = r_phase[0];
    assign step_o   = r_step;
    assign dir_o    = r_dir;
    assign period_o = w_period;

endmodule

// File: doc/steer_quad_accel.md
# steer_quad_accel

Converts the digital left/right steering controls from the arcade input mapper into a two-phase quadrature pair with a step rate that accelerates while held. It sits directly upstream of the game core's `Steer_*A_I`/`Steer_*B_I` inputs, so a joystick or keyboard behaves like the cabinet's rotary steering encoder: slow for fine correction, faster on a sustained turn.

## Interface
Parameters:
- `DIV_MAX`, 45000: initial step period in `CLK` cycles; must be ≤ 65535.
- `DIV_MIN`, 9000: fastest step period in cycles; must satisfy 2 ≤ `DIV_MIN` ≤ `DIV_MAX`.
- `ACCEL_STEP`, 1500: amount subtracted from the period after each emitted step.

Ports:
- `CLK` in 1: system clock (12.096 MHz domain). One clock only.
- `reset` in 1: synchronous, active-high reset.
- `c_left` in 1: active-high left request, level.
- `c_right` in 1: active-high right request, level.
- `steerA` out 1: quadrature phase A.
- `steerB` out 1: quadrature phase B.
- `step_o` out 1: one-cycle pulse coincident with each phase change.
- `dir_o` out 1: direction of the last step, 1 = right.
- `period_o` out 16: period in use for the next step.

## Operation
- Inputs are registered once into `l_q`/`r_q`. All decisions use the registered values.
- FSM states are `IDLE`, `RUN_R` and `RUN_L`, decoded from `{l_q,r_q}`:
  - 01 selects `RUN_R`.
  - 10 selects `RUN_L`.
  - 00 or 11 selects `IDLE`. Both pressed cancels.
- Entering any `RUN` state from `IDLE` or from the opposite `RUN` state loads `cnt`=0 and `period`=`DIV_MAX`. A direction reversal takes effect directly, with no intermediate `IDLE` cycle.
- In `RUN`:
  - `cnt` increments each cycle.
  - When `cnt == period-1`, a step fires: phase advances, `cnt` is set to 0, and `period` is set to max(`period`-`ACCEL_STEP`, `DIV_MIN`).
  - The subtraction is done in 17 bits so it cannot underflow.
- Phase encoding `{steerA,steerB}`:
  - Right steps the sequence 00→10→11→01→00. A leads B.
  - Left steps the reverse sequence, 00→01→11→10→00.
  - Wrap-around is seamless.
- In `IDLE`:
  - Phase holds its last value; it is never forced to 00 except by reset.
  - `cnt` is held at 0 and `period` at `DIV_MAX`.
- `dir_o` updates only when a step fires.
- Reset values: `steerA`=0, `steerB`=0, `step_o`=0, `dir_o`=0, `period_o`=`DIV_MAX`, state `IDLE`, `cnt`=0, `l_q`=`r_q`=0.
- Reset asserted mid-run overrides everything on that edge. After release, the block restarts from `IDLE` using newly registered inputs.

## Timing
- Call E0 the edge that first registers a press.
  - The state enters `RUN` at E0+1.
  - The first phase change appears at E0+1+`DIV_MAX`.
- Subsequent steps are spaced by exactly the updated `period`, with zero-cycle gaps between periods.
- Release, registered at edge R, moves to `IDLE` at R+1. A step due at R+1 is suppressed.
- `step_o`, `steerA`/`steerB`, `dir_o` and `period_o` are all registered and change on the same edge.
- A reversal at step-due time: the reversal wins and no step is emitted on that edge.
- Throughput: one step per `period` cycles, with a minimum of `DIV_MIN` cycles between steps.

## Structure
- Shared package `steer_pkg` holds:
  - the FSM state enum (`IDLE`, `RUN_R`, `RUN_L`);
  - the 2-bit Gray phase constants;
  - the next-phase functions `phase_cw()` and `phase_ccw()`.
- The natural sub-module is `steer_rate_ctr`. It takes `load`, `run` and `step` inputs and produces `cnt`, `period` and `step_due`, keeping the period/acceleration arithmetic separate from the FSM and phase logic.

## Test plan
All scenarios use `DIV_MAX`=10, `DIV_MIN`=4, `ACCEL_STEP`=3.
- Reset, then idle: all outputs stay at their reset values and `period_o`=10 for 100 cycles with no `step_o`.
- Hold `c_right` from E0: steps at E0+11, +7, +4, +4 thereafter; phase goes 00→10→11→01→00; `dir_o`=1; `period_o` goes 10→7→4→4.
- Hold `c_left` from a held phase of 11: the next phases are 10, then 00; `dir_o`=0.
- Press right, then switch to left 2 cycles after the third step: `period_o` returns to 10, the next step follows 11 cycles after the switch registers, and it moves in the ccw direction.
- Both inputs high while running: no further steps, phase frozen, `period_o`=10 one cycle after both are registered.
- Assert `reset` mid-run one cycle before a due step: no step is emitted and all outputs return to their reset values on that edge.
